// File: rtl/game_pkg.sv
// Shared definitions for the game session controller slice.
// Contents:
//   game_state_t : FSM state encodings (IDLE=0 .. OVER=5), also exported on the state port
//   dir_t        : one-hot sprite direction codes used by the movement units
//   LIVES_W      : width of the lives counter
//   LEVEL_W      : width of the level counter
//   next_level() : level advance with wrap from 15 back to 1
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  typedef enum logic [3:0] {
    RIGHT = 4'b0001,
    UP    = 4'b0010,
    DOWN  = 4'b0100,
    LEFT  = 4'b1000
  } dir_t;

  // Level 0 is never used, so the wrap skips it.
  function automatic logic [LEVEL_W-1:0] next_level(input logic [LEVEL_W-1:0] lvl);
    return (lvl == {LEVEL_W{1'b1}}) ? LEVEL_W'(1) : lvl + LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/game_session_controller_if.sv
// Bus between the game session controller and its surroundings.
// Inputs to the controller (driven by the master side):
//   tick, start, food_eaten    : strobes / level request
//   pacman_x, pacman_y         : pacman pixel position
//   ghost_x, ghost_y           : packed ghost pixel positions, ghost 0 in the LSBs
// Outputs of the controller (driven by the slave side):
//   state, move_en, respawn, hit_vec, lives, level, score, game_over
interface game_session_controller_if
  import game_pkg::*;
#(
  parameter int N_GHOSTS = 4,
  parameter int POS_X_W  = 11,
  parameter int POS_Y_W  = 10,
  parameter int SCORE_W  = 12
);

  logic                          tick;
  logic                          start;
  logic                          food_eaten;
  logic [POS_X_W-1:0]            pacman_x;
  logic [POS_Y_W-1:0]            pacman_y;
  logic [N_GHOSTS*POS_X_W-1:0]   ghost_x;
  logic [N_GHOSTS*POS_Y_W-1:0]   ghost_y;

  logic [2:0]                    state;
  logic                          move_en;
  logic                          respawn;
  logic [N_GHOSTS-1:0]           hit_vec;
  logic [LIVES_W-1:0]            lives;
  logic [LEVEL_W-1:0]            level;
  logic [SCORE_W-1:0]            score;
  logic                          game_over;

  modport master (
    output tick, start, food_eaten, pacman_x, pacman_y, ghost_x, ghost_y,
    input  state, move_en, respawn, hit_vec, lives, level, score, game_over
  );

  modport slave (
    input  tick, start, food_eaten, pacman_x, pacman_y, ghost_x, ghost_y,
    output state, move_en, respawn, hit_vec, lives, level, score, game_over
  );

endinterface

// File: rtl/ghost_tile_hit.sv
// Tile-level collision detector for one ghost.
// Ports:
//   clk, rst (async, active-low)
//   pacman_x/pacman_y : pacman pixel position
//   ghost_x/ghost_y   : this ghost's pixel position
//   hit               : registered flag, high when both share a tile
module ghost_tile_hit #(
  parameter int POS_X_W    = 11,
  parameter int POS_Y_W    = 10,
  parameter int TILE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [POS_X_W-1:0] pacman_x,
  input  logic [POS_Y_W-1:0] pacman_y,
  input  logic [POS_X_W-1:0] ghost_x,
  input  logic [POS_Y_W-1:0] ghost_y,
  output logic               hit
);

  // Dropping the in-tile offset bits leaves the tile coordinate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit <= 1'b0;
    end else begin
      hit <= ((pacman_x >> TILE_SHIFT) == (ghost_x >> TILE_SHIFT)) &&
             ((pacman_y >> TILE_SHIFT) == (ghost_y >> TILE_SHIFT));
    end
  end

endmodule

// File: rtl/game_session_controller.sv
// Game session controller: sequences IDLE/READY/PLAY/DYING/CLEAR/OVER and owns
// lives, level, score and the remaining-food count of a play session.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : game_session_controller_if.slave (strobes, positions in; state,
//          move_en, respawn, hit_vec, lives, level, score, game_over out)
// Configuration macro:
//   GSC_EXTRA_LIFE_EN : when defined, one bonus life per session the first time
//                       score reaches EXTRA_LIFE_SCORE (lives saturate at 7).
module game_session_controller
  import game_pkg::*;
#(
  parameter int N_GHOSTS         = 4,
  parameter int POS_X_W          = 11,
  parameter int POS_Y_W          = 10,
  parameter int TILE_SHIFT       = 4,
  parameter int SCORE_W          = 12,
  parameter int FOOD_TOTAL       = 300,
  parameter int LIVES_INIT       = 3,
  parameter int READY_TICKS      = 120,
  parameter int DYING_TICKS      = 60,
  parameter int EXTRA_LIFE_SCORE = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  game_session_controller_if.slave  bus
);

  localparam int                  PHASE_W     = 16;
  localparam int                  FOOD_W      = 12;
  localparam logic [PHASE_W-1:0]  READY_LAST  = PHASE_W'(READY_TICKS - 1);
  localparam logic [PHASE_W-1:0]  DYING_LAST  = PHASE_W'(DYING_TICKS - 1);
  localparam logic [FOOD_W-1:0]   FOOD_INIT   = FOOD_W'(FOOD_TOTAL);
  localparam logic [LIVES_W-1:0]  LIVES_RESET = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0]  LIVES_MAX   = {LIVES_W{1'b1}};
  localparam logic [SCORE_W-1:0]  SCORE_MAX   = {SCORE_W{1'b1}};

  game_state_t          state_q;
  logic                 move_en_q;
  logic                 respawn_q;
  logic                 game_over_q;
  logic [LIVES_W-1:0]   lives_q;
  logic [LEVEL_W-1:0]   level_q;
  logic [SCORE_W-1:0]   score_q;
  logic [FOOD_W-1:0]    food_left;
  logic [PHASE_W-1:0]   phase;
  logic                 start_armed;
  logic [N_GHOSTS-1:0]  hit_q;
  logic                 any_hit;

  logic                 food_take;
  logic [SCORE_W-1:0]   score_next;
  logic [FOOD_W-1:0]    food_next;
  logic                 extra_life;
  logic [LIVES_W-1:0]   lives_play;
  logic                 begin_session;

  // One registered tile comparator per ghost.
  for (genvar i = 0; i < N_GHOSTS; i++) begin : g_hit
    ghost_tile_hit #(
      .POS_X_W    (POS_X_W),
      .POS_Y_W    (POS_Y_W),
      .TILE_SHIFT (TILE_SHIFT)
    ) u_hit (
      .clk      (clk),
      .rst      (rst),
      .pacman_x (bus.pacman_x),
      .pacman_y (bus.pacman_y),
      .ghost_x  (bus.ghost_x[i*POS_X_W +: POS_X_W]),
      .ghost_y  (bus.ghost_y[i*POS_Y_W +: POS_Y_W]),
      .hit      (hit_q[i])
    );
  end

  assign any_hit = |hit_q;

`ifdef GSC_EXTRA_LIFE_EN
  localparam logic [SCORE_W-1:0] XL_SCORE = SCORE_W'(EXTRA_LIFE_SCORE);
  logic bonus_given;

  // Sticky once-per-session bonus flag; it only rearms when a new session starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bonus_given <= 1'b0;
    end else if (begin_session || state_q == IDLE) begin
      bonus_given <= 1'b0;
    end else if (extra_life) begin
      bonus_given <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (EXTRA_LIFE_SCORE == 0);
`endif

  // Pellet bookkeeping and lives arithmetic for the PLAY state. A pellet
  // landing together with a hit is still scored; the hit decides the transition.
  always_comb begin
    food_take  = (state_q == PLAY) && bus.food_eaten;
    score_next = score_q;
    food_next  = food_left;
    if (food_take && score_q != SCORE_MAX) score_next = score_q + SCORE_W'(1);
    if (food_take && food_left != '0)      food_next  = food_left - FOOD_W'(1);

    extra_life = 1'b0;
`ifdef GSC_EXTRA_LIFE_EN
    if (!bonus_given && score_q < XL_SCORE && score_next >= XL_SCORE) extra_life = 1'b1;
`endif

    lives_play = lives_q;
    if (any_hit && lives_q != '0)            lives_play = lives_q - LIVES_W'(1);
    if (extra_life && lives_play != LIVES_MAX) lives_play = lives_play + LIVES_W'(1);

    // OVER only restarts on a fresh rising start, tracked by start_armed.
    begin_session = ((state_q == IDLE) && bus.start) ||
                    ((state_q == OVER) && start_armed && bus.start);
  end

  // Session FSM with registered outputs; phase restarts at every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      move_en_q   <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      lives_q     <= LIVES_RESET;
      level_q     <= LEVEL_W'(1);
      score_q     <= '0;
      food_left   <= FOOD_INIT;
      phase       <= '0;
      start_armed <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      if (begin_session) begin
        state_q     <= READY;
        respawn_q   <= 1'b1;
        move_en_q   <= 1'b0;
        game_over_q <= 1'b0;
        score_q     <= '0;
        lives_q     <= LIVES_RESET;
        level_q     <= LEVEL_W'(1);
        food_left   <= FOOD_INIT;
        phase       <= '0;
        start_armed <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
          end
          READY: begin
            if (bus.tick) begin
              if (phase == READY_LAST) begin
                state_q   <= PLAY;
                move_en_q <= 1'b1;
                phase     <= '0;
              end else begin
                phase <= phase + PHASE_W'(1);
              end
            end
          end
          PLAY: begin
            score_q   <= score_next;
            food_left <= food_next;
            lives_q   <= lives_play;
            if (any_hit) begin
              state_q   <= DYING;
              move_en_q <= 1'b0;
              phase     <= '0;
            end else if (food_left == '0) begin
              state_q   <= CLEAR;
              move_en_q <= 1'b0;
              phase     <= '0;
            end
          end
          DYING: begin
            if (bus.tick) begin
              if (phase == DYING_LAST) begin
                phase <= '0;
                if (lives_q == '0) begin
                  state_q     <= OVER;
                  game_over_q <= 1'b1;
                  start_armed <= 1'b0;
                end else begin
                  state_q   <= READY;
                  respawn_q <= 1'b1;
                end
              end else begin
                phase <= phase + PHASE_W'(1);
              end
            end
          end
          CLEAR: begin
            if (bus.tick) begin
              if (phase == DYING_LAST) begin
                phase     <= '0;
                level_q   <= next_level(level_q);
                food_left <= FOOD_INIT;
                state_q   <= READY;
                respawn_q <= 1'b1;
              end else begin
                phase <= phase + PHASE_W'(1);
              end
            end
          end
          OVER: begin
            if (!bus.start) start_armed <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.move_en   = move_en_q;
  assign bus.respawn   = respawn_q;
  assign bus.hit_vec   = hit_q;
  assign bus.lives     = lives_q;
  assign bus.level     = level_q;
  assign bus.score     = score_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_session_controller.sv
// Self-checking bench for game_session_controller with randomized positions,
// tick spacing and pellet spacing, checked against a session-level model.
// Honours GSC_EXTRA_LIFE_EN in the model when the macro is defined.
module tb_game_session_controller;

  localparam int NG = 4, XW = 11, YW = 10, TS = 4, SW = 12;
  localparam int FT = 4, LI = 3, RT = 120, DT = 60, XL = 3;
  localparam int TILE = 1 << TS;
  localparam logic [2:0] S_IDLE = 3'd0, S_READY = 3'd1, S_PLAY = 3'd2,
                         S_DYING = 3'd3, S_CLEAR = 3'd4, S_OVER = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_session_controller_if #(.N_GHOSTS(NG), .POS_X_W(XW), .POS_Y_W(YW), .SCORE_W(SW)) dut_if ();

  game_session_controller #(
    .N_GHOSTS(NG), .POS_X_W(XW), .POS_Y_W(YW), .TILE_SHIFT(TS), .SCORE_W(SW),
    .FOOD_TOTAL(FT), .LIVES_INIT(LI), .READY_TICKS(RT), .DYING_TICKS(DT),
    .EXTRA_LIFE_SCORE(XL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Session-level reference model.
  int m_lives, m_level, m_score, m_food;
  bit m_bonus;
  int px, py;
  int gx [NG];
  int gy [NG];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pos();
    dut_if.pacman_x = XW'(px);
    dut_if.pacman_y = YW'(py);
    for (int i = 0; i < NG; i++) begin
      dut_if.ghost_x[i*XW +: XW] = XW'(gx[i]);
      dut_if.ghost_y[i*YW +: YW] = YW'(gy[i]);
    end
  endtask

  // Pacman in the top band, ghosts far below: never on a shared tile.
  task automatic park();
    px = $urandom_range(0, 150);
    py = $urandom_range(0, 150);
    for (int i = 0; i < NG; i++) begin
      gx[i] = $urandom_range(0, 2000);
      gy[i] = $urandom_range(400, 700);
    end
    drive_pos();
  endtask

  // Put ghost g and pacman on a random common tile.
  task automatic collide(input int g);
    int tx, ty;
    tx = $urandom_range(2, 40);
    ty = $urandom_range(2, 20);
    px = tx * TILE + $urandom_range(0, TILE - 1);
    py = ty * TILE + $urandom_range(0, TILE - 1);
    gx[g] = tx * TILE + $urandom_range(0, TILE - 1);
    gy[g] = ty * TILE + $urandom_range(0, TILE - 1);
    drive_pos();
  endtask

  function automatic logic [NG-1:0] model_hits();
    logic [NG-1:0] r;
    for (int i = 0; i < NG; i++)
      r[i] = (px / TILE == gx[i] / TILE) && (py / TILE == gy[i] / TILE);
    return r;
  endfunction

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step();
      dut_if.tick = 1'b1;
      step();
      dut_if.tick = 1'b0;
    end
  endtask

  // Pellet eaten while in PLAY, applied to the model by the game rules.
  task automatic eat();
    int old;
    dut_if.food_eaten = 1'b1;
    step();
    dut_if.food_eaten = 1'b0;
    old = m_score;
    if (m_score < (1 << SW) - 1) m_score++;
    if (m_food > 0) m_food--;
`ifdef GSC_EXTRA_LIFE_EN
    if (!m_bonus && old < XL && m_score >= XL) begin
      m_bonus = 1'b1;
      if (m_lives < 7) m_lives++;
    end
`else
    if (old < 0) m_bonus = 1'b1;
`endif
  endtask

  task automatic new_session_model();
    m_lives = LI; m_level = 1; m_score = 0; m_food = FT; m_bonus = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (3) step();
    n_cmp++; if (dut_if.state !== S_IDLE) begin n_bad++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut_if.state, S_IDLE); end
    n_cmp++; if (dut_if.move_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_move_en: got %b expected 0", dut_if.move_en); end
    n_cmp++; if (dut_if.respawn !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_respawn: got %b expected 0", dut_if.respawn); end
    n_cmp++; if (dut_if.hit_vec !== '0) begin n_bad++; $display("[TB] FAIL reset_hit_vec: got %b expected 0", dut_if.hit_vec); end
    n_cmp++; if (dut_if.lives !== 3'(LI)) begin n_bad++; $display("[TB] FAIL reset_lives: got %0d expected %0d", dut_if.lives, LI); end
    n_cmp++; if (dut_if.level !== 4'd1) begin n_bad++; $display("[TB] FAIL reset_level: got %0d expected 1", dut_if.level); end
    n_cmp++; if (dut_if.score !== '0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d expected 0", dut_if.score); end
    n_cmp++; if (dut_if.game_over !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_game_over: got %b expected 0", dut_if.game_over); end
    rst = 1'b1;
    repeat ($urandom_range(1, 4)) step();
    n_cmp++; if (dut_if.state !== S_IDLE) begin n_bad++; $display("[TB] FAIL idle_hold: got %0d expected %0d", dut_if.state, S_IDLE); end
  endtask

  task automatic test_start();
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    new_session_model();
    n_cmp++; if (dut_if.respawn !== 1'b1) begin n_bad++; $display("[TB] FAIL start_respawn: got %b expected 1", dut_if.respawn); end
    n_cmp++; if (dut_if.state !== S_READY) begin n_bad++; $display("[TB] FAIL start_state: got %0d expected %0d", dut_if.state, S_READY); end
    step();
    n_cmp++; if (dut_if.respawn !== 1'b0) begin n_bad++; $display("[TB] FAIL start_respawn_width: got %b expected 0", dut_if.respawn); end
    run_ticks(RT - 1);
    n_cmp++; if (dut_if.state !== S_READY) begin n_bad++; $display("[TB] FAIL ready_early: got %0d expected %0d", dut_if.state, S_READY); end
    n_cmp++; if (dut_if.move_en !== 1'b0) begin n_bad++; $display("[TB] FAIL ready_move_en: got %b expected 0", dut_if.move_en); end
    run_ticks(1);
    n_cmp++; if (dut_if.state !== S_PLAY) begin n_bad++; $display("[TB] FAIL ready_to_play: got %0d expected %0d", dut_if.state, S_PLAY); end
    n_cmp++; if (dut_if.move_en !== 1'b1) begin n_bad++; $display("[TB] FAIL play_move_en: got %b expected 1", dut_if.move_en); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL play_lives: got %0d expected %0d", dut_if.lives, m_lives); end
  endtask

  task automatic test_collision();
    int j, tx, ty;
    // Adjacent tiles, one pixel apart across a tile boundary: no hit.
    j = $urandom_range(0, NG - 1);
    tx = $urandom_range(2, 40);
    ty = $urandom_range(2, 20);
    px = tx * TILE + TILE - 1;
    py = ty * TILE + $urandom_range(0, TILE - 1);
    gx[j] = (tx + 1) * TILE;
    gy[j] = ty * TILE + $urandom_range(0, TILE - 1);
    drive_pos();
    step(); step();
    n_cmp++; if (dut_if.hit_vec !== model_hits()) begin n_bad++; $display("[TB] FAIL near_miss_hit_vec: got %b expected %b", dut_if.hit_vec, model_hits()); end
    n_cmp++; if (dut_if.state !== S_PLAY) begin n_bad++; $display("[TB] FAIL near_miss_state: got %0d expected %0d", dut_if.state, S_PLAY); end
    // Ghost 2 at (160,32), pacman at (170,40).
    park();
    gx[2] = 160; gy[2] = 32; px = 170; py = 40;
    drive_pos();
    step();
    n_cmp++; if (dut_if.hit_vec !== model_hits()) begin n_bad++; $display("[TB] FAIL hit_vec_g2: got %b expected %b", dut_if.hit_vec, model_hits()); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL hit_lives_early: got %0d expected %0d", dut_if.lives, m_lives); end
    step();
    m_lives--;
    n_cmp++; if (dut_if.state !== S_DYING) begin n_bad++; $display("[TB] FAIL hit_state: got %0d expected %0d", dut_if.state, S_DYING); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL hit_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    n_cmp++; if (dut_if.move_en !== 1'b0) begin n_bad++; $display("[TB] FAIL dying_move_en: got %b expected 0", dut_if.move_en); end
    park();
    run_ticks(DT - 1);
    n_cmp++; if (dut_if.state !== S_DYING) begin n_bad++; $display("[TB] FAIL dying_early: got %0d expected %0d", dut_if.state, S_DYING); end
    run_ticks(1);
    n_cmp++; if (dut_if.state !== S_READY) begin n_bad++; $display("[TB] FAIL dying_to_ready: got %0d expected %0d", dut_if.state, S_READY); end
    n_cmp++; if (dut_if.respawn !== 1'b1) begin n_bad++; $display("[TB] FAIL dying_respawn: got %b expected 1", dut_if.respawn); end
  endtask

  task automatic test_game_over();
    for (int h = 0; h < 2; h++) begin
      run_ticks(RT);
      collide($urandom_range(0, NG - 1));
      step();
      n_cmp++; if (dut_if.hit_vec !== model_hits()) begin n_bad++; $display("[TB] FAIL rand_hit_vec: got %b expected %b", dut_if.hit_vec, model_hits()); end
      step();
      m_lives--;
      n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL rand_hit_lives: got %0d expected %0d", dut_if.lives, m_lives); end
      park();
      if (h == 1) dut_if.start = 1'b1;
      run_ticks(DT);
    end
    n_cmp++; if (dut_if.state !== S_OVER) begin n_bad++; $display("[TB] FAIL over_state: got %0d expected %0d", dut_if.state, S_OVER); end
    n_cmp++; if (dut_if.game_over !== 1'b1) begin n_bad++; $display("[TB] FAIL over_flag: got %b expected 1", dut_if.game_over); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL over_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    repeat ($urandom_range(3, 8)) step();
    n_cmp++; if (dut_if.state !== S_OVER) begin n_bad++; $display("[TB] FAIL over_start_held: got %0d expected %0d", dut_if.state, S_OVER); end
    dut_if.start = 1'b0;
    step();
    dut_if.start = 1'b1;
    step();
    dut_if.start = 1'b0;
    new_session_model();
    n_cmp++; if (dut_if.state !== S_READY) begin n_bad++; $display("[TB] FAIL restart_state: got %0d expected %0d", dut_if.state, S_READY); end
    n_cmp++; if (dut_if.respawn !== 1'b1) begin n_bad++; $display("[TB] FAIL restart_respawn: got %b expected 1", dut_if.respawn); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL restart_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    n_cmp++; if (dut_if.game_over !== 1'b0) begin n_bad++; $display("[TB] FAIL restart_game_over: got %b expected 0", dut_if.game_over); end
  endtask

  task automatic test_food_clear();
    run_ticks(RT);
    for (int k = 0; k < FT; k++) begin
      if (k > 1) repeat ($urandom_range(0, 2)) step();
      eat();
      n_cmp++; if (dut_if.score !== SW'(m_score)) begin n_bad++; $display("[TB] FAIL pellet_score: got %0d expected %0d", dut_if.score, m_score); end
      n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL pellet_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    end
    n_cmp++; if (dut_if.state !== S_PLAY) begin n_bad++; $display("[TB] FAIL clear_early: got %0d expected %0d", dut_if.state, S_PLAY); end
    step();
    n_cmp++; if (dut_if.state !== S_CLEAR) begin n_bad++; $display("[TB] FAIL clear_state: got %0d expected %0d", dut_if.state, S_CLEAR); end
    dut_if.food_eaten = 1'b1;
    step();
    dut_if.food_eaten = 1'b0;
    n_cmp++; if (dut_if.score !== SW'(m_score)) begin n_bad++; $display("[TB] FAIL clear_food_ignored: got %0d expected %0d", dut_if.score, m_score); end
    run_ticks(DT);
    m_level++;
    m_food = FT;
    n_cmp++; if (dut_if.state !== S_READY) begin n_bad++; $display("[TB] FAIL clear_to_ready: got %0d expected %0d", dut_if.state, S_READY); end
    n_cmp++; if (dut_if.respawn !== 1'b1) begin n_bad++; $display("[TB] FAIL clear_respawn: got %b expected 1", dut_if.respawn); end
    n_cmp++; if (dut_if.level !== 4'(m_level)) begin n_bad++; $display("[TB] FAIL clear_level: got %0d expected %0d", dut_if.level, m_level); end
    n_cmp++; if (dut_if.score !== SW'(m_score)) begin n_bad++; $display("[TB] FAIL clear_score_kept: got %0d expected %0d", dut_if.score, m_score); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL clear_lives_kept: got %0d expected %0d", dut_if.lives, m_lives); end
  endtask

  task automatic test_food_hit_same_cycle();
    run_ticks(RT);
    for (int k = 0; k < FT - 1; k++) eat();
    n_cmp++; if (dut_if.score !== SW'(m_score)) begin n_bad++; $display("[TB] FAIL l2_score: got %0d expected %0d", dut_if.score, m_score); end
    collide($urandom_range(0, NG - 1));
    step();
    n_cmp++; if (dut_if.hit_vec !== model_hits()) begin n_bad++; $display("[TB] FAIL same_cycle_hit_vec: got %b expected %b", dut_if.hit_vec, model_hits()); end
    eat();
    m_lives--;
    n_cmp++; if (dut_if.state !== S_DYING) begin n_bad++; $display("[TB] FAIL same_cycle_state: got %0d expected %0d", dut_if.state, S_DYING); end
    n_cmp++; if (dut_if.score !== SW'(m_score)) begin n_bad++; $display("[TB] FAIL same_cycle_score: got %0d expected %0d", dut_if.score, m_score); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL same_cycle_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    step();
    n_cmp++; if (dut_if.state !== S_DYING) begin n_bad++; $display("[TB] FAIL same_cycle_no_clear: got %0d expected %0d", dut_if.state, S_DYING); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    new_session_model();
    n_cmp++; if (dut_if.state !== S_IDLE) begin n_bad++; $display("[TB] FAIL async_state: got %0d expected %0d", dut_if.state, S_IDLE); end
    n_cmp++; if (dut_if.lives !== 3'(m_lives)) begin n_bad++; $display("[TB] FAIL async_lives: got %0d expected %0d", dut_if.lives, m_lives); end
    n_cmp++; if (dut_if.score !== '0) begin n_bad++; $display("[TB] FAIL async_score: got %0d expected 0", dut_if.score); end
    n_cmp++; if (dut_if.level !== 4'd1) begin n_bad++; $display("[TB] FAIL async_level: got %0d expected 1", dut_if.level); end
    n_cmp++; if (dut_if.hit_vec !== '0) begin n_bad++; $display("[TB] FAIL async_hit_vec: got %b expected 0", dut_if.hit_vec); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (dut_if.hit_vec !== model_hits()) begin n_bad++; $display("[TB] FAIL post_reset_hit_vec: got %b expected %b", dut_if.hit_vec, model_hits()); end
  endtask

  initial begin
    dut_if.tick       = 1'b0;
    dut_if.start      = 1'b0;
    dut_if.food_eaten = 1'b0;
    park();
    new_session_model();
    test_reset();
    test_start();
    test_collision();
    test_game_over();
    test_food_clear();
    test_food_hit_same_cycle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
